// File: rtl/bc_tx_msg_reader_if.sv
// Handshake and bus bundle between the BC TX message reader, TX RAM port B
// and the Manchester encoder.
//   start/start_addr/abort : message control from the host
//   ram_addr/ram_ren/ram_blk_en/ram_dout : TX RAM port B read side
//   tx_word/tx_sync/tx_valid/tx_ready : word stream to the encoder
//   busy/done/err/word_cnt : message status
// The slave modport is the reader; master is everything around it.
interface bc_tx_msg_reader_if #(
  parameter int unsigned ADDR_W = 10
) ();
  localparam int unsigned RAM_W  = 40;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 6;

  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              abort;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_ren;
  logic              ram_blk_en;
  logic [RAM_W-1:0]  ram_dout;
  logic [WORD_W-1:0] tx_word;
  logic              tx_sync;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              done;
  logic              err;
  logic [CNT_W-1:0]  word_cnt;

  modport master (
    output start, start_addr, abort, ram_dout, tx_ready,
    input  ram_addr, ram_ren, ram_blk_en, tx_word, tx_sync, tx_valid,
           busy, done, err, word_cnt
  );

  modport slave (
    input  start, start_addr, abort, ram_dout, tx_ready,
    output ram_addr, ram_ren, ram_blk_en, tx_word, tx_sync, tx_valid,
           busy, done, err, word_cnt
  );
endinterface

// File: rtl/bc_tx_msg_reader.sv
// Reads one BC transmit message from TX RAM port B (sync read, 1-cycle
// latency) and hands it word by word to the 1553 encoder over valid/ready.
// A message ends at the first word with EOM set or after MAX_WORDS words.
// Ports:
//   clk : single clock, shared with RAM port B
//   rst : asynchronous active-high reset
//   bus : bc_tx_msg_reader_if.slave (host control, RAM port B, encoder, status)
// RAM word: [15:0] data, [16] sync type (1 = command/status), [17] EOM.
module bc_tx_msg_reader #(
  parameter int unsigned MAX_WORDS = 33,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic               clk,
  input  logic               rst,
  bc_tx_msg_reader_if.slave  bus
);
  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 6;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] READ    = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] PRESENT = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              eom;
  logic              eom_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              ren_nxt;
  logic [WORD_W-1:0] tx_word_nxt;
  logic              tx_sync_nxt;
  logic              tx_valid_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic              err_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CNT_W-1:0]  cnt_inc;

  // RAM bits above the EOM flag carry nothing for the encoder.
  logic unused_ram_bits;
  assign unused_ram_bits = ^bus.ram_dout[39:18];

  // State register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      eom            <= 1'b0;
      bus.ram_addr   <= '0;
      bus.ram_ren    <= 1'b0;
      bus.ram_blk_en <= 1'b0;
      bus.tx_word    <= '0;
      bus.tx_sync    <= 1'b0;
      bus.tx_valid   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
      bus.word_cnt   <= '0;
    end else begin
      state          <= state_nxt;
      eom            <= eom_nxt;
      bus.ram_addr   <= addr_nxt;
      bus.ram_ren    <= ren_nxt;
      bus.ram_blk_en <= ren_nxt;
      bus.tx_word    <= tx_word_nxt;
      bus.tx_sync    <= tx_sync_nxt;
      bus.tx_valid   <= tx_valid_nxt;
      bus.busy       <= busy_nxt;
      bus.done       <= done_nxt;
      bus.err        <= err_nxt;
      bus.word_cnt   <= cnt_nxt;
    end
  end

  // Next-state and next-output logic; ren_nxt is high exactly when the
  // next state is READ so the RAM strobe lines up with that state.
  always_comb begin
    state_nxt    = state;
    eom_nxt      = eom;
    addr_nxt     = bus.ram_addr;
    ren_nxt      = 1'b0;
    tx_word_nxt  = bus.tx_word;
    tx_sync_nxt  = bus.tx_sync;
    tx_valid_nxt = bus.tx_valid;
    busy_nxt     = bus.busy;
    done_nxt     = 1'b0;
    err_nxt      = bus.err;
    cnt_nxt      = bus.word_cnt;
    cnt_inc      = bus.word_cnt + CNT_W'(1);

    if (state != IDLE && bus.abort) begin
      // Abort beats a same-cycle handshake; the word count is left as is.
      state_nxt    = IDLE;
      tx_valid_nxt = 1'b0;
      busy_nxt     = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state_nxt = READ;
            addr_nxt  = bus.start_addr;
            cnt_nxt   = '0;
            err_nxt   = 1'b0;
            busy_nxt  = 1'b1;
            ren_nxt   = 1'b1;
          end
        end
        READ: begin
          state_nxt = CAPTURE;
        end
        CAPTURE: begin
          tx_word_nxt  = bus.ram_dout[15:0];
          tx_sync_nxt  = bus.ram_dout[16];
          eom_nxt      = bus.ram_dout[17];
          tx_valid_nxt = 1'b1;
          state_nxt    = PRESENT;
        end
        PRESENT: begin
          if (bus.tx_ready) begin
            cnt_nxt      = cnt_inc;
            tx_valid_nxt = 1'b0;
            if (eom || cnt_inc == CNT_W'(MAX_WORDS)) begin
              err_nxt   = ~eom;
              done_nxt  = 1'b1;
              busy_nxt  = 1'b0;
              state_nxt = IDLE;
            end else begin
              // Wraps modulo 2^ADDR_W.
              addr_nxt  = bus.ram_addr + ADDR_W'(1);
              ren_nxt   = 1'b1;
              state_nxt = READ;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/bc_tx_msg_reader.md
# bc_tx_msg_reader

Reads one BC transmit message out of port B of the BC TX RAM (1024 x 40, synchronous read, 1-cycle latency) and presents it word by word to the 1553 Manchester encoder over a valid/ready handshake. A message starts at a host-supplied RAM address. It ends at the first RAM word whose end-of-message flag is set, or is cut off at MAX_WORDS words. The block owns port B read-side control: address, read enable and block enable. It sits directly downstream of the TX RAM and upstream of the encoder.

## Interface
- MAX_WORDS, 33, word limit per message (1 command + 32 data); legal range 1..63
- ADDR_W, 10, RAM address width
- CLK  in  1  single clock; RAM port B clock is driven from the same net
- RESET  in  1  asynchronous, active-high reset
- START  in  1  single-cycle pulse that begins a message; ignored while BUSY=1
- START_ADDR  in  ADDR_W  RAM address of the first message word, sampled when START is accepted
- ABORT  in  1  level; terminates the current message
- RAM_ADDR  out  ADDR_W  port B address
- RAM_REN  out  1  port B read enable
- RAM_BLK_EN  out  1  port B block enable; high only while a read is issued
- RAM_DOUT  in  40  port B read data, valid 1 cycle after RAM_REN
- TX_WORD  out  16  word to the encoder
- TX_SYNC  out  1  1 = command/status sync, 0 = data sync
- TX_VALID  out  1  TX_WORD/TX_SYNC valid
- TX_READY  in  1  encoder accepts the word
- BUSY  out  1  message in progress
- DONE  out  1  single-cycle pulse at normal or limit termination
- ERR  out  1  sticky: message hit MAX_WORDS with no EOM; cleared on the next accepted START
- WORD_CNT  out  6  number of words accepted by the encoder in the current or last message

## Operation
- RAM word format: [15:0] data, [16] sync type, [17] EOM, [39:18] ignored.
- States:
  - IDLE
    - START → READ; latch addr=START_ADDR; WORD_CNT←0; ERR←0; BUSY←1.
  - READ
    - RAM_REN=RAM_BLK_EN=1, RAM_ADDR=addr.
    - Next state: CAPTURE.
  - CAPTURE
    - TX_WORD←RAM_DOUT[15:0], TX_SYNC←RAM_DOUT[16], eom←RAM_DOUT[17], TX_VALID←1.
    - Next state: PRESENT.
  - PRESENT
    - Hold TX_VALID, TX_WORD and TX_SYNC stable until TX_READY.
    - On the handshake: WORD_CNT+1 and TX_VALID←0.
    - If eom=1: DONE pulse → IDLE.
    - Else if WORD_CNT+1 = MAX_WORDS: ERR←1, DONE pulse → IDLE.
    - Else: addr←addr+1 → READ.
- Address arithmetic is modulo 2^ADDR_W; 1023 wraps to 0 with no flag.
- ABORT=1 in any non-IDLE state:
  - Next cycle: IDLE, TX_VALID=0, RAM_REN=0, BUSY=0, no DONE pulse.
  - WORD_CNT keeps the count of words already accepted.
- ABORT has priority over a same-cycle handshake: that word is not counted.
- START in the same cycle as ABORT while IDLE: START wins and ABORT is ignored.
- A START pulse while BUSY=1 has no effect.
- RAM_REN and RAM_BLK_EN are 0 in every state except READ.

## Timing
- Reset value of every output is 0; the FSM resets to IDLE.
- RESET in mid-message: all outputs go to 0 immediately (asynchronous); no DONE pulse.
- START accepted at cycle 0:
  - RAM_REN=1 at cycle 1.
  - TX_VALID=1 from cycle 3.
- Handshake at cycle n:
  - TX_VALID=0 at n+1.
  - Next RAM_REN at n+1; next TX_VALID at n+3.
  - Steady-state throughput is one word per 3 cycles when TX_READY is held high.
- DONE is asserted in the cycle after the final handshake. BUSY falls in that same cycle.
- A new START is accepted from the cycle DONE is high.
- TX_WORD holds its last value after TX_VALID drops.

## Test plan
- Message at 0x010:
  - Stimulus: RAM[0x010..0x012] = {sync=1, 0x0823}, {sync=0, 0x1234}, {sync=0, EOM=1, 0xBEEF}; START_ADDR=0x010; TX_READY=1.
  - Required: 3 words in order with sync 1,0,0; DONE one cycle after the third handshake; WORD_CNT=3; ERR=0.
- Encoder back-pressure:
  - Stimulus: same message; TX_READY low for 10 cycles on word 2.
  - Required: TX_WORD stays 0x1234 and TX_VALID stays high for all 10 cycles; no extra RAM_REN pulse.
- Address wrap:
  - Stimulus: START_ADDR=0x3FF; RAM[0x3FF]=0x0001; RAM[0x000] has EOM=1 with data 0x0002.
  - Required: RAM_ADDR sequence 0x3FF then 0x000; output 0x0001, 0x0002; DONE.
- Word limit:
  - Stimulus: MAX_WORDS=33; 40 RAM words with no EOM.
  - Required: exactly 33 words; ERR=1 and DONE pulse; WORD_CNT=33; ERR clears on the next START.
- Abort:
  - Stimulus: ABORT=1 during PRESENT of word 2 while TX_READY=1.
  - Required: IDLE next cycle; TX_VALID=0; no DONE; WORD_CNT=1. A START while BUSY is ignored (address unchanged).
- Reset mid-message:
  - Stimulus: assert RESET during READ.
  - Required: RAM_REN, TX_VALID, BUSY and WORD_CNT are 0 asynchronously; after release, a START runs a full message normally.
